// File: rtl/alu_exec.sv
// ALU execute stage with a 2-entry in-order result buffer.
// Results are computed on accept and held until the consumer pops them.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             branch_taken,
  output logic             illegal,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             branch;
    logic             illegal;
  } entry_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_BNE = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_BGZ = 4'b1111;

  state_t           state;
  entry_t           head;
  entry_t           tail;
  entry_t           new_entry;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] lui_value;
  logic             push;
  logic             pop;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign diff      = a - b;
  assign lui_value = {{(WIDTH-16){1'b0}}, b[15:0]} << 16;

  always_comb begin
    new_entry         = '0;
    new_entry.illegal = 1'b0;
    unique case (control)
      OP_ADD: new_entry.result = a + b;
      OP_SUB: begin
        new_entry.result = diff;
        new_entry.branch = (a == b);
      end
      OP_AND: new_entry.result = a & b;
      OP_OR:  new_entry.result = a | b;
      OP_NOR: new_entry.result = ~(a | b);
      OP_SLT: new_entry.result = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      OP_LUI: new_entry.result = lui_value;
      OP_BGZ: begin
        new_entry.result = a;
        new_entry.branch = ~a[WIDTH-1];
      end
      OP_BNE: begin
        new_entry.result = diff;
        new_entry.branch = (a != b);
      end
      default: begin
        new_entry.result  = '0;
        new_entry.illegal = 1'b1;
      end
    endcase
    new_entry.zero = (new_entry.result == '0);
  end

  // Head slot is cleared whenever the buffer drains so idle outputs read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      head      <= '0;
      tail      <= '0;
      err_count <= '0;
    end else begin
      if (push && new_entry.illegal && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= new_entry;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= new_entry;
          end else if (push) begin
            tail  <= new_entry;
            state <= FULL;
          end else if (pop) begin
            head  <= '0;
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head  <= tail;
            tail  <= '0;
            state <= ONE;
          end
        end
        default: begin
          head  <= '0;
          tail  <= '0;
          state <= EMPTY;
        end
      endcase
    end
  end

  assign result       = head.result;
  assign zero         = head.zero;
  assign branch_taken = head.branch;
  assign illegal      = head.illegal;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, queue-based
// random reference model, and hand-written backpressure/reset sequences.
module tb_alu_exec;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   control = 4'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         branch_taken;
  logic         illegal;
  logic [7:0]   err_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [W-1:0] result;
    logic         zero;
    logic         branch;
    logic         illegal;
  } exp_t;

  typedef struct {
    logic [3:0]   control;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         exp;
  } vec_t;

  exp_t model_q[$];
  int   model_err = 0;

  alu_exec #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .control      (control),
    .a            (a),
    .b            (b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .zero         (zero),
    .branch_taken (branch_taken),
    .illegal      (illegal),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  // Reference semantics expressed with signed integer arithmetic.
  function automatic exp_t ref_model(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   sx;
    int   sy;
    sx = int'(x);
    sy = int'(y);
    e.result = '0;
    e.branch = 1'b0;
    e.illegal = 1'b0;
    case (c)
      4'b0010: e.result = x + y;
      4'b0110: begin e.result = x - y; e.branch = (x == y); end
      4'b0000: e.result = x & y;
      4'b0001: e.result = x | y;
      4'b1100: e.result = ~(x | y);
      4'b0111: e.result = (sx < sy) ? 32'd1 : 32'd0;
      4'b0101: e.result = y * 32'h0001_0000;
      4'b1111: begin e.result = x; e.branch = (sx >= 0); end
      4'b1010: begin e.result = x - y; e.branch = (x != y); end
      default: e.illegal = 1'b1;
    endcase
    e.zero = (e.result == 0);
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] r, input logic z, input logic br, input logic il);
    exp_t e;
    e.result = r;
    e.zero = z;
    e.branch = br;
    e.illegal = il;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] c, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic r);
    in_valid = v;
    control = c;
    a = x;
    b = y;
    out_ready = r;
  endtask

  task automatic check_head(input string tag, input logic valid_exp, input exp_t e);
    exp_t z;
    z = mk('0, 1'b0, 1'b0, 1'b0);
    if (!valid_exp) e = z;
    checkOutput({tag, ".out_valid"}, W'(out_valid), W'(valid_exp));
    checkOutput({tag, ".result"}, result, e.result);
    checkOutput({tag, ".zero"}, W'(zero), W'(e.zero));
    checkOutput({tag, ".branch_taken"}, W'(branch_taken), W'(e.branch));
    checkOutput({tag, ".illegal"}, W'(illegal), W'(e.illegal));
  endtask

  initial begin
    vec_t vecs[12];
    exp_t none;
    logic acc;
    logic pop;
    logic [3:0] c;
    logic [W-1:0] x;
    logic [W-1:0] y;

    none = mk('0, 1'b0, 1'b0, 1'b0);
    vecs[0]  = '{4'b0010, 32'hFFFF_FFFF, 32'h1, mk(32'h0, 1, 0, 0)};
    vecs[1]  = '{4'b0111, 32'hFFFF_FFFE, 32'h1, mk(32'h1, 0, 0, 0)};
    vecs[2]  = '{4'b0111, 32'h1, 32'hFFFF_FFFE, mk(32'h0, 1, 0, 0)};
    vecs[3]  = '{4'b0101, 32'hDEAD_BEEF, 32'h0000_1234, mk(32'h1234_0000, 0, 0, 0)};
    vecs[4]  = '{4'b1100, 32'h0, 32'h0, mk(32'hFFFF_FFFF, 0, 0, 0)};
    vecs[5]  = '{4'b0110, 32'h5, 32'h5, mk(32'h0, 1, 1, 0)};
    vecs[6]  = '{4'b1010, 32'h5, 32'h5, mk(32'h0, 1, 0, 0)};
    vecs[7]  = '{4'b1111, 32'h8000_0000, 32'h0, mk(32'h8000_0000, 0, 0, 0)};
    vecs[8]  = '{4'b1111, 32'h0, 32'h7, mk(32'h0, 1, 1, 0)};
    vecs[9]  = '{4'b0000, 32'h0000_F0F0, 32'h0000_FF00, mk(32'h0000_F000, 0, 0, 0)};
    vecs[10] = '{4'b0001, 32'h0000_F0F0, 32'h0000_FF00, mk(32'h0000_FFF0, 0, 0, 0)};
    vecs[11] = '{4'b0011, 32'h1234, 32'h5678, mk(32'h0, 1, 0, 1)};

    // Reset: in_ready high, outputs cleared, no accept on an edge under reset.
    applyStimulus(1'b1, 4'b0010, 32'h1, 32'h2, 1'b1);
    #1;
    checkOutput("reset.in_ready", W'(in_ready), W'(1'b1));
    checkOutput("reset.err_count", W'(err_count), 32'd0);
    check_head("reset", 1'b0, none);
    @(negedge clk);
    check_head("reset_edge", 1'b0, none);
    applyStimulus(1'b0, 4'b0, '0, '0, 1'b1);
    #2 rst_n = 1'b1;

    // Directed vector table, one op at a time.
    foreach (vecs[i]) begin
      @(negedge clk);
      checkOutput("table.idle_valid", W'(out_valid), 32'd0);
      applyStimulus(1'b1, vecs[i].control, vecs[i].a, vecs[i].b, 1'b1);
      if (vecs[i].exp.illegal && model_err < 255) model_err++;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check_head($sformatf("table[%0d]", i), 1'b1, vecs[i].exp);
      checkOutput("table.err_count", W'(err_count), W'(model_err));
      @(posedge clk);
    end

    // Random traffic against the queue model.
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      check_head("rand", model_q.size() > 0, (model_q.size() > 0) ? model_q[0] : none);
      checkOutput("rand.in_ready", W'(in_ready), W'(model_q.size() < 2));
      checkOutput("rand.err_count", W'(err_count), W'(model_err));
      c = 4'($urandom_range(0, 15));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? x : $urandom;
      if ($urandom_range(0, 3) == 0) x = {1'b0, x[W-2:0]};
      applyStimulus($urandom_range(0, 3) != 0, c, x, y, $urandom_range(0, 2) != 0);
      acc = in_valid && (model_q.size() < 2);
      pop = out_ready && (model_q.size() > 0);
      @(posedge clk);
      if (pop) void'(model_q.pop_front());
      if (acc) begin
        model_q.push_back(ref_model(c, x, y));
        if (model_q[$].illegal && model_err < 255) model_err++;
      end
    end
    @(negedge clk);
    applyStimulus(1'b0, 4'b0, '0, '0, 1'b1);
    repeat (3) @(posedge clk);
    model_q.delete();
    @(negedge clk);
    check_head("drain", 1'b0, none);

    // Backpressure: two ops fill the buffer, a third is refused.
    applyStimulus(1'b1, 4'b0010, 32'd1, 32'd2, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp.in_ready_one", W'(in_ready), 32'd1);
    applyStimulus(1'b1, 4'b0110, 32'd9, 32'd4, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp.in_ready_full", W'(in_ready), 32'd0);
    applyStimulus(1'b1, 4'b0011, 32'd100, 32'd100, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_head("bp.held", 1'b1, mk(32'd3, 0, 0, 0));
    checkOutput("bp.err_unchanged", W'(err_count), W'(model_err));
    applyStimulus(1'b0, 4'b0011, 32'd7, 32'd7, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check_head("bp.second", 1'b1, mk(32'd5, 0, 0, 0));
    checkOutput("bp.in_ready_back", W'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_head("bp.empty", 1'b0, none);

    // Streaming illegal codes at full rate saturates the error counter.
    applyStimulus(1'b1, 4'b0011, $urandom, $urandom, 1'b1);
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_head("illegal_stream", 1'b1, mk(32'd0, 1, 0, 1));
      a = $urandom;
      b = $urandom;
      if (k == 299) in_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("sat.err_count", W'(err_count), 32'd255);
    check_head("sat.empty", 1'b0, none);

    // Reset pulse between edges while FULL and backpressured.
    applyStimulus(1'b1, 4'b0010, 32'd7, 32'd8, 1'b0);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 4'b0001, 32'd1, 32'd2, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mid.full", W'(in_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_head("rst_mid.during", 1'b0, none);
    checkOutput("rst_mid.err_count", W'(err_count), 32'd0);
    checkOutput("rst_mid.in_ready", W'(in_ready), 32'd1);
    applyStimulus(1'b1, 4'b0010, 32'd20, 32'd22, 1'b1);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_head("rst_mid.after", 1'b1, mk(32'd42, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    check_head("rst_mid.alone", 1'b0, none);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation offered.
REQ-005 SHALL have port in_ready  output  1  operation accepted when in_valid && in_ready at clk edge.
REQ-006 SHALL have port control  input  4  ALU control code from the ALU control decoder.
REQ-007 SHALL have ports a, b  input  WIDTH  operands (a = rs, b = rt/immediate).
REQ-008 SHALL have port out_valid  output  1  result entry available.
REQ-009 SHALL have port out_ready  input  1  consumer pops the head entry when out_valid && out_ready at clk edge.
REQ-010 SHALL have port result  output  WIDTH  head-entry result.
REQ-011 SHALL have port zero  output  1  head-entry result == 0.
REQ-012 SHALL have port branch_taken  output  1  head-entry branch condition.
REQ-013 SHALL have port illegal  output  1  head-entry control code not decoded.
REQ-014 SHALL have port err_count  output  8  saturating count of accepted illegal codes.

Function
REQ-015 On accept, SHALL compute per control: 0010 a+b; 0110 a-b; 0000 a&b; 0001 a|b; 1100 ~(a|b); 0111 signed a<b ? 1 : 0; 0101 {b[15:0], 16'h0}; 1111 result=a; 1010 result=a-b.
REQ-016 Add/sub SHALL wrap modulo 2^WIDTH; no overflow flag or trap.
REQ-017 branch_taken SHALL be (a==b) for 0110, (a!=b) for 1010, ~a[WIDTH-1] for 1111, 0 for all other codes.
REQ-018 Any other control code SHALL store result 0, zero 1, branch_taken 0, illegal 1.
REQ-019 zero SHALL be computed from the stored result, never from operands.
REQ-020 Computed entries SHALL be written into a 2-entry in-order output buffer; result/zero/branch_taken/illegal SHALL always present the head entry.
REQ-021 Buffer states SHALL be EMPTY (0 entries), ONE (1), FULL (2); out_valid = state != EMPTY; in_ready = state != FULL, combinational from state only.
REQ-022 Transitions: push-only EMPTY->ONE->FULL; pop-only FULL->ONE->EMPTY; push+pop in ONE stays ONE with new entry at head next cycle; push impossible in FULL.
REQ-023 Latency: operation accepted at edge N SHALL appear on outputs after edge N if buffer was EMPTY (1 cycle); it SHALL never bypass older entries.
REQ-024 Throughput: with out_ready held 1, one operation per cycle SHALL be sustained indefinitely.
REQ-025 out_ready while EMPTY SHALL be ignored; in_valid while FULL SHALL be ignored (no accept, no err_count change).
REQ-026 Head outputs with out_valid=0 SHALL be 0.
REQ-027 err_count SHALL increment by 1 on each accepted illegal code, saturate at 255, never decrement, and be unaffected by pops.
REQ-028 Held entries SHALL remain stable while out_valid && !out_ready, irrespective of a, b, control changes.

Reset
REQ-029 rst_n low SHALL immediately force state EMPTY, out_valid 0, result 0, zero 0, branch_taken 0, illegal 0, err_count 0, discarding buffered entries.
REQ-030 in_ready SHALL read 1 during reset, but no accept SHALL occur until the first rising edge with rst_n high.
REQ-031 Reset asserted mid-stream (FULL, backpressured) SHALL drop both entries with no partial pop.

Verification
REQ-032 Reset, then ADD a=0xFFFFFFFF b=1, out_ready=1 -> next cycle out_valid 1, result 0x00000000, zero 1, branch_taken 0.
REQ-033 SLT a=0xFFFFFFFE(-2) b=1 -> result 1; LUI b=0x00001234 -> result 0x12340000; NOR a=0 b=0 -> 0xFFFFFFFF.
REQ-034 Branches: 0110 a=b=5 -> branch_taken 1, zero 1; 1010 a=5 b=5 -> branch_taken 0; 1111 a=0x80000000 -> branch_taken 0; 1111 a=0 -> branch_taken 1.
REQ-035 out_ready=0, push ADD(1,2), SUB(9,4), then third op -> in_ready 0 after 2nd accept, third not accepted; raise out_ready -> results 3 then 5 in order, in_ready returns 1.
REQ-036 Push 300 ops with control 0011 -> every entry illegal 1, result 0; err_count ends at 255.
REQ-037 With buffer FULL, pulse rst_n low between edges -> out_valid 0 and err_count 0 immediately, next accepted op appears alone after 1 cycle.
